// File: rtl/encoder8_3_seq.sv
// ============================================================================
//  Module      : encoder8_3_seq
//  Description : Sequential 8-to-3 encoder. Accepts a request vector and
//                streams the index of every set bit, lowest first, one beat
//                per handshake. An all-zero vector yields a single "zero"
//                beat. Popcount and zero flag are held until the next accept.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module encoder8_3_seq #(
  parameter int WIDTH_OUT = 3,
  parameter int WIDTH_IN  = 8   // must equal 2**WIDTH_OUT
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 A_valid_in,
  input  logic [WIDTH_IN-1:0]  A_in,
  output logic                 A_ready_out,
  output logic                 Y_valid_out,
  input  logic                 Y_ready_in,
  output logic [WIDTH_OUT-1:0] Y_out,
  output logic                 Y_last_out,
  output logic                 Y_zero_out,
  output logic [WIDTH_OUT:0]   Y_count_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_ZERO = 2'd2
  } state_t;

  // Index of the lowest set bit (0 when the vector is empty).
  function automatic logic [WIDTH_OUT-1:0] lowest_index(input logic [WIDTH_IN-1:0] v);
    logic [WIDTH_OUT-1:0] idx;
    idx = '0;
    for (int i = WIDTH_IN - 1; i >= 0; i--) begin
      if (v[i]) idx = i[WIDTH_OUT-1:0];
    end
    return idx;
  endfunction

  // True when exactly one bit of the vector is set.
  function automatic logic is_single(input logic [WIDTH_IN-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // Population count; one extra bit so an all-ones vector does not wrap.
  function automatic logic [WIDTH_OUT:0] popcount(input logic [WIDTH_IN-1:0] v);
    logic [WIDTH_OUT:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH_IN; i++) begin
      cnt = cnt + {{WIDTH_OUT{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  state_t               r_state;
  logic [WIDTH_IN-1:0]  r_pending;
  logic                 r_a_ready;
  logic                 r_y_valid;
  logic [WIDTH_OUT-1:0] r_y_out;
  logic                 r_y_last;
  logic                 r_y_zero;
  logic [WIDTH_OUT:0]   r_y_count;

  logic [WIDTH_IN-1:0]  w_emit_mask;
  logic [WIDTH_IN-1:0]  w_pending_next;
  logic [WIDTH_OUT-1:0] w_in_lowest;
  logic                 w_in_single;
  logic [WIDTH_OUT:0]   w_in_count;
  logic [WIDTH_OUT-1:0] w_next_lowest;
  logic                 w_next_single;

  // Helper decodes: incoming vector, and the pending vector after the current beat retires.
  always_comb begin
    w_emit_mask    = {{(WIDTH_IN-1){1'b0}}, 1'b1} << r_y_out;
    w_pending_next = r_pending & ~w_emit_mask;
    w_in_lowest    = lowest_index(A_in);
    w_in_single    = is_single(A_in);
    w_in_count     = popcount(A_in);
    w_next_lowest  = lowest_index(w_pending_next);
    w_next_single  = is_single(w_pending_next);
  end

  // Control FSM with all outputs registered; the next beat is precomputed on each transition.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
      r_a_ready <= 1'b1;
      r_y_valid <= 1'b0;
      r_y_out   <= '0;
      r_y_last  <= 1'b0;
      r_y_zero  <= 1'b0;
      r_y_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (A_valid_in) begin
            r_a_ready <= 1'b0;
            r_y_valid <= 1'b1;
            r_y_count <= w_in_count;
            if (A_in == '0) begin
              r_state   <= ST_ZERO;
              r_pending <= '0;
              r_y_out   <= '0;
              r_y_last  <= 1'b1;
              r_y_zero  <= 1'b1;
            end else begin
              r_state   <= ST_SCAN;
              r_pending <= A_in;
              r_y_out   <= w_in_lowest;
              r_y_last  <= w_in_single;
              r_y_zero  <= 1'b0;
            end
          end
        end

        ST_SCAN: begin
          if (Y_ready_in) begin
            r_pending <= w_pending_next;
            if (r_y_last) begin
              r_state   <= ST_IDLE;
              r_a_ready <= 1'b1;
              r_y_valid <= 1'b0;
              r_y_out   <= '0;
              r_y_last  <= 1'b0;
            end else begin
              r_y_out  <= w_next_lowest;
              r_y_last <= w_next_single;
            end
          end
        end

        ST_ZERO: begin
          if (Y_ready_in) begin
            r_state   <= ST_IDLE;
            r_a_ready <= 1'b1;
            r_y_valid <= 1'b0;
            r_y_out   <= '0;
            r_y_last  <= 1'b0;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_pending <= '0;
          r_a_ready <= 1'b1;
          r_y_valid <= 1'b0;
          r_y_out   <= '0;
          r_y_last  <= 1'b0;
        end
      endcase
    end
  end

  assign A_ready_out = r_a_ready;
  assign Y_valid_out = r_y_valid;
  assign Y_out       = r_y_out;
  assign Y_last_out  = r_y_last;
  assign Y_zero_out  = r_y_zero;
  assign Y_count_out = r_y_count;

endmodule

`default_nettype wire

// File: tb/tb_encoder8_3_seq.sv
// ============================================================================
//  Module      : tb_encoder8_3_seq
//  Description : Scoreboard bench for encoder8_3_seq. Stimulus pushes the
//                expected beats (with expected cycle); a negedge monitor pops
//                and compares every completed beat.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_encoder8_3_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_valid = 1'b0;
  logic [7:0] a_in = 8'h00;
  logic       y_ready = 1'b0;
  logic       a_ready;
  logic       y_valid;
  logic [2:0] y_out;
  logic       y_last;
  logic       y_zero;
  logic [3:0] y_count;

  encoder8_3_seq #(.WIDTH_OUT(3), .WIDTH_IN(8)) dut (
    .clk_in     (clk),
    .rst_n_in   (rst_n),
    .A_valid_in (a_valid),
    .A_in       (a_in),
    .A_ready_out(a_ready),
    .Y_valid_out(y_valid),
    .Y_ready_in (y_ready),
    .Y_out      (y_out),
    .Y_last_out (y_last),
    .Y_zero_out (y_zero),
    .Y_count_out(y_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int y;
    int last;
    int zero;
    int cnt;
    int cyc;
  } beat_t;

  beat_t q[$];
  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endfunction

  function automatic void push(input int y, input int last, input int zero, input int cnt, input int c);
    beat_t b;
    b.y = y; b.last = last; b.zero = zero; b.cnt = cnt; b.cyc = c;
    q.push_back(b);
  endfunction

  // Monitor: a beat completes on the next rising edge when valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n && y_valid && y_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_beat_y", int'(y_out), -1);
      end else begin
        beat_t b;
        b = q.pop_front();
        chk("beat_y",     int'(y_out),   b.y);
        chk("beat_last",  int'(y_last),  b.last);
        chk("beat_zero",  int'(y_zero),  b.zero);
        chk("beat_count", int'(y_count), b.cnt);
        chk("beat_cycle", cyc,           b.cyc);
      end
    end
  end

  // Offer a vector; called #1 after a rising edge, returns #1 after the accepting edge.
  task automatic accept(input logic [7:0] v, output int acc_cyc);
    a_valid = 1'b1;
    a_in    = v;
    @(negedge clk);
    chk("a_ready_before_accept", int'(a_ready), 1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    a_valid = 1'b0;
    a_in    = 8'h00;
  endtask

  // Wait for all expected beats, then check the bubble cycle and held status.
  task automatic drain(input int exp_cnt, input int exp_zero);
    int t;
    t = 0;
    while (q.size() != 0 && t < 60) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_leftover_beats", q.size(), 0);
    q.delete();
    @(negedge clk);
    chk("idle_valid", int'(y_valid), 0);
    chk("idle_ready", int'(a_ready), 1);
    chk("idle_y",     int'(y_out),   0);
    chk("idle_last",  int'(y_last),  0);
    chk("idle_count", int'(y_count), exp_cnt);
    chk("idle_zero",  int'(y_zero),  exp_zero);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;

    // Reset, release, no stimulus
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_a_ready", int'(a_ready), 1);
    chk("rst_valid",   int'(y_valid), 0);
    chk("rst_count",   int'(y_count), 0);
    chk("rst_zero",    int'(y_zero),  0);
    @(posedge clk);
    #1;

    // Single set bit
    y_ready = 1'b1;
    accept(8'b0000_0001, a);
    push(0, 1, 0, 1, a);
    drain(1, 0);

    // Sparse vector: 2, 5, 7 on consecutive cycles
    accept(8'b1010_0100, a);
    push(2, 0, 0, 3, a);
    push(5, 0, 0, 3, a + 1);
    push(7, 1, 0, 3, a + 2);
    drain(3, 0);

    // All ones with three stalled cycles
    y_ready = 1'b0;
    accept(8'hFF, a);
    for (int i = 0; i < 8; i++) push(i, (i == 7) ? 1 : 0, 0, 8, a + 3 + i);
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", int'(y_valid), 1);
      chk("stall_y",     int'(y_out),   0);
      chk("stall_last",  int'(y_last),  0);
      chk("stall_count", int'(y_count), 8);
      @(posedge clk);
      #1;
    end
    y_ready = 1'b1;
    drain(8, 0);

    // Zero vector, with the next vector held during its beat
    accept(8'h00, a);
    a_valid = 1'b1;
    a_in    = 8'h0F;
    push(0, 1, 1, 0, a);
    for (int i = 0; i < 4; i++) push(i, (i == 3) ? 1 : 0, 0, 4, a + 2 + i);
    @(negedge clk);
    chk("zero_beat_a_ready", int'(a_ready), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bubble_a_ready", int'(a_ready), 1);
    chk("bubble_valid",   int'(y_valid), 0);
    chk("bubble_zero",    int'(y_zero),  1);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    a_in    = 8'h00;
    drain(4, 0);

    // Reset in the middle of a scan, then a fresh vector
    accept(8'hFF, a);
    push(0, 0, 0, 8, a);
    push(1, 0, 0, 8, a + 1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_valid",   int'(y_valid), 0);
    chk("midrst_y",       int'(y_out),   0);
    chk("midrst_last",    int'(y_last),  0);
    chk("midrst_zero",    int'(y_zero),  0);
    chk("midrst_count",   int'(y_count), 0);
    chk("midrst_a_ready", int'(a_ready), 1);
    chk("midrst_beats_left", q.size(), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    accept(8'h80, a);
    push(7, 1, 0, 1, a);
    drain(1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
